// File: rtl/stack_seq_pkg.sv
// Shared types for the stack micro-sequencer: op codes, FSM states, strobe bundle.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package stack_seq_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEC      = 4'd1,
        ADDR     = 4'd2,
        WRITE    = 4'd3,
        WRITE_PC = 4'd4,
        JUMP     = 4'd5,
        READ     = 4'd6,
        READ_PC  = 4'd7,
        INC      = 4'd8,
        ERR      = 4'd9
    } state_e;

    // Datapath control strobes, one bit per enable/drive line.
    typedef struct packed {
        logic spe;
        logic spd;
        logic spo;
        logic pce;
        logic pcw;
        logic pco;
        logic mae;
        logic mem_we;
        logic mem_oe;
        logic rin;
        logic rou;
    } strobe_t;

    // PUSH and CALL grow the stack; POP and RET shrink it.
    function automatic logic op_grows(input op_e o);
        return (o == OP_PUSH) || (o == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_depth_ctr.sv
// Saturating up/down occupancy counter with full/empty flags.
// Latency: depth updates on the edge after inc/dec is sampled; flags are combinational from depth.
// Backpressure: none; inc at full and dec at empty are ignored.
// Ports: clk, reset (sync, active-high), inc, dec, depth, full, empty.
module stack_depth_ctr
    import stack_seq_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (inc && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Micro-sequencer issuing PUSH/POP/CALL/RET as fixed one-cycle control-strobe steps.
// Latency: start at edge N -> steps N+1..N+k (k=3, CALL k=4), done in N+k; rejected ops take one ERR cycle.
// Backpressure: start is sampled only while idle (busy=0); pulses while busy are dropped.
// Ports: clk, reset (sync, active-high), start/op/reg_sel command; busy/done/err_* status;
//        depth occupancy; c_* datapath strobes; sel_in register select.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [2:0]         reg_sel,
    output logic               busy,
    output logic               done,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic [DEPTH_W-1:0] depth,
    output logic               c_spe,
    output logic               c_spd,
    output logic               c_spo,
    output logic               c_pce,
    output logic               c_pcw,
    output logic               c_pco,
    output logic               c_mae,
    output logic               c_mem_we,
    output logic               c_mem_oe,
    output logic               c_rin,
    output logic               c_rou,
    output logic [2:0]         sel_in
);

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [2:0] reg_q, reg_d;
    strobe_t    stb;
    logic       full, empty;

    // Depth moves on the edge that ends the SP adjust step, tracking the SP itself.
    stack_depth_ctr #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q == DEC),
        .dec   (state_q == INC),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        reg_d   = reg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op_e'(op);
                    reg_d = reg_sel;
                    // Bounds check up front so a rejected op never touches the datapath.
                    if (op_grows(op_e'(op))) begin
                        state_d = full ? ERR : DEC;
                    end else begin
                        state_d = empty ? ERR : ADDR;
                    end
                end
            end
            DEC:  state_d = ADDR;
            ADDR: begin
                case (op_q)
                    OP_PUSH: state_d = WRITE;
                    OP_CALL: state_d = WRITE_PC;
                    OP_POP:  state_d = READ;
                    default: state_d = READ_PC;
                endcase
            end
            WRITE_PC: state_d = JUMP;
            READ:     state_d = INC;
            READ_PC:  state_d = INC;
            default:  state_d = IDLE;   // WRITE, JUMP, INC, ERR all finish here
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_PUSH;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            reg_q   <= reg_d;
        end
    end

    // Strobe decode; each step drives at most one bus source.
    always_comb begin
        stb = '0;
        case (state_q)
            DEC:      begin stb.spe = 1'b1; stb.spd = 1'b1; end
            ADDR:     begin stb.spo = 1'b1; stb.mae = 1'b1; end
            WRITE:    begin stb.rou = 1'b1; stb.mem_we = 1'b1; end
            WRITE_PC: begin stb.pco = 1'b1; stb.mem_we = 1'b1; end
            JUMP:     begin stb.rou = 1'b1; stb.pce = 1'b1; stb.pcw = 1'b1; end
            READ:     begin stb.mem_oe = 1'b1; stb.rin = 1'b1; end
            READ_PC:  begin stb.mem_oe = 1'b1; stb.pce = 1'b1; stb.pcw = 1'b1; end
            INC:      begin stb.spe = 1'b1; end
            default:  stb = '0;
        endcase
    end

    assign c_spe    = stb.spe;
    assign c_spd    = stb.spd;
    assign c_spo    = stb.spo;
    assign c_pce    = stb.pce;
    assign c_pcw    = stb.pcw;
    assign c_pco    = stb.pco;
    assign c_mae    = stb.mae;
    assign c_mem_we = stb.mem_we;
    assign c_mem_oe = stb.mem_oe;
    assign c_rin    = stb.rin;
    assign c_rou    = stb.rou;

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == WRITE) || (state_q == JUMP) ||
                    (state_q == INC)   || (state_q == ERR);
    assign err_overflow  = (state_q == ERR) &&  op_grows(op_q);
    assign err_underflow = (state_q == ERR) && !op_grows(op_q);
    assign sel_in = busy ? reg_q : 3'd0;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: per-scenario tasks with hand-computed step vectors.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: exercises start held high while busy.
module tb_stack_sequencer;

    localparam logic [10:0] B_SPE = 11'h400;
    localparam logic [10:0] B_SPD = 11'h200;
    localparam logic [10:0] B_SPO = 11'h100;
    localparam logic [10:0] B_PCE = 11'h080;
    localparam logic [10:0] B_PCW = 11'h040;
    localparam logic [10:0] B_PCO = 11'h020;
    localparam logic [10:0] B_MAE = 11'h010;
    localparam logic [10:0] B_WE  = 11'h008;
    localparam logic [10:0] B_OE  = 11'h004;
    localparam logic [10:0] B_RIN = 11'h002;
    localparam logic [10:0] B_ROU = 11'h001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'd0;
    logic [2:0] reg_sel = 3'd0;
    logic       busy, done, err_overflow, err_underflow;
    logic [4:0] depth;
    logic       c_spe, c_spd, c_spo, c_pce, c_pcw, c_pco, c_mae;
    logic       c_mem_we, c_mem_oe, c_rin, c_rou;
    logic [2:0] sel_in;

    int vecs = 0;
    int errs = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    stack_sequencer #(.STACK_DEPTH(16), .DEPTH_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .reg_sel(reg_sel),
        .busy(busy), .done(done), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .depth(depth),
        .c_spe(c_spe), .c_spd(c_spd), .c_spo(c_spo),
        .c_pce(c_pce), .c_pcw(c_pcw), .c_pco(c_pco),
        .c_mae(c_mae), .c_mem_we(c_mem_we), .c_mem_oe(c_mem_oe),
        .c_rin(c_rin), .c_rou(c_rou), .sel_in(sel_in)
    );

    function automatic logic [10:0] strb();
        return {c_spe, c_spd, c_spo, c_pce, c_pcw, c_pco, c_mae, c_mem_we, c_mem_oe, c_rin, c_rou};
    endfunction

    // {strobes[10:0], busy, done, err_overflow, err_underflow, sel_in[2:0], depth[4:0]}
    function automatic logic [22:0] snap();
        return {strb(), busy, done, err_overflow, err_underflow, sel_in, depth};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle command; returns in cycle N+1 (first step).
    task automatic send(input logic [1:0] o, input logic [2:0] r);
        start = 1'b1; op = o; reg_sel = r;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // At most one bus driver per cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            vecs++;
            if ($countones({c_rou, c_pco, c_spo, c_mem_oe}) > 1) begin
                $display("FAIL bus_excl t=%0t: drivers rou/pco/spo/oe=%b required at most one",
                         $time, {c_rou, c_pco, c_spo, c_mem_oe});
                errs++;
            end
        end
    end

    task automatic test_reset();
        tick();
        tick();
        vecs++;
        if (snap() !== 23'd0) begin
            $display("FAIL reset_state: got %h required %h", snap(), 23'd0);
            errs++;
        end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_push();
        logic [22:0] exp [4];
        exp[0] = {B_SPE | B_SPD, 1'b1, 1'b0, 2'b00, 3'd2, 5'd0};
        exp[1] = {B_SPO | B_MAE, 1'b1, 1'b0, 2'b00, 3'd2, 5'd1};
        exp[2] = {B_ROU | B_WE,  1'b1, 1'b1, 2'b00, 3'd2, 5'd1};
        exp[3] = {11'd0,         1'b0, 1'b0, 2'b00, 3'd0, 5'd1};
        send(2'd0, 3'd2);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (snap() !== exp[i]) begin
                $display("FAIL push step%0d: got %h required %h", i, snap(), exp[i]);
                errs++;
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_pop();
        logic [22:0] exp [4];
        exp[0] = {B_SPO | B_MAE, 1'b1, 1'b0, 2'b00, 3'd5, 5'd1};
        exp[1] = {B_OE | B_RIN,  1'b1, 1'b0, 2'b00, 3'd5, 5'd1};
        exp[2] = {B_SPE,         1'b1, 1'b1, 2'b00, 3'd5, 5'd1};
        exp[3] = {11'd0,         1'b0, 1'b0, 2'b00, 3'd0, 5'd0};
        send(2'd1, 3'd5);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (snap() !== exp[i]) begin
                $display("FAIL pop step%0d: got %h required %h", i, snap(), exp[i]);
                errs++;
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_call_ret();
        logic [22:0] ec [5];
        logic [22:0] er [4];
        ec[0] = {B_SPE | B_SPD,         1'b1, 1'b0, 2'b00, 3'd1, 5'd0};
        ec[1] = {B_SPO | B_MAE,         1'b1, 1'b0, 2'b00, 3'd1, 5'd1};
        ec[2] = {B_PCO | B_WE,          1'b1, 1'b0, 2'b00, 3'd1, 5'd1};
        ec[3] = {B_ROU | B_PCE | B_PCW, 1'b1, 1'b1, 2'b00, 3'd1, 5'd1};
        ec[4] = {11'd0,                 1'b0, 1'b0, 2'b00, 3'd0, 5'd1};
        er[0] = {B_SPO | B_MAE,         1'b1, 1'b0, 2'b00, 3'd0, 5'd1};
        er[1] = {B_OE | B_PCE | B_PCW,  1'b1, 1'b0, 2'b00, 3'd0, 5'd1};
        er[2] = {B_SPE,                 1'b1, 1'b1, 2'b00, 3'd0, 5'd1};
        er[3] = {11'd0,                 1'b0, 1'b0, 2'b00, 3'd0, 5'd0};
        send(2'd2, 3'd1);
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (snap() !== ec[i]) begin
                $display("FAIL call step%0d: got %h required %h", i, snap(), ec[i]);
                errs++;
            end
            if (i < 4) tick();
        end
        send(2'd3, 3'd0);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (snap() !== er[i]) begin
                $display("FAIL ret step%0d: got %h required %h", i, snap(), er[i]);
                errs++;
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_overflow();
        logic [22:0] exp0, exp1;
        exp0 = {11'd0, 1'b1, 1'b1, 2'b10, 3'd7, 5'd16};
        exp1 = {11'd0, 1'b0, 1'b0, 2'b00, 3'd0, 5'd16};
        for (int i = 0; i < 16; i++) begin
            send(2'd0, 3'(i));
            tick(); tick(); tick();
        end
        vecs++;
        if (depth !== 5'd16) begin
            $display("FAIL fill_depth: got %0d required 16", depth);
            errs++;
        end
        send(2'd0, 3'd7);
        vecs++;
        if (snap() !== exp0) begin
            $display("FAIL overflow_err: got %h required %h", snap(), exp0);
            errs++;
        end
        tick();
        vecs++;
        if (snap() !== exp1) begin
            $display("FAIL overflow_after: got %h required %h", snap(), exp1);
            errs++;
        end
    endtask

    task automatic test_underflow();
        logic [22:0] exp0;
        exp0 = {11'd0, 1'b1, 1'b1, 2'b01, 3'd4, 5'd0};
        do_reset();
        vecs++;
        if (depth !== 5'd0) begin
            $display("FAIL reset_depth: got %0d required 0", depth);
            errs++;
        end
        send(2'd1, 3'd4);
        vecs++;
        if (snap() !== exp0) begin
            $display("FAIL underflow_err: got %h required %h", snap(), exp0);
            errs++;
        end
        tick();
        vecs++;
        if (snap() !== 23'd0) begin
            $display("FAIL underflow_after: got %h required %h", snap(), 23'd0);
            errs++;
        end
    endtask

    // start held high; op flips to POP while busy so a wrongly sampled pulse shows up.
    task automatic test_back_to_back();
        logic [6:0] exp;
        do_reset();
        start = 1'b1; op = 2'd0; reg_sel = 3'd3;
        tick();
        for (int j = 1; j <= 12; j++) begin
            exp = {((j % 4) != 0), ((j % 4) == 3), 5'((j + 2) / 4)};
            vecs++;
            if ({busy, done, depth} !== exp) begin
                $display("FAIL b2b offset%0d: busy/done/depth got %b/%b/%0d required %b/%b/%0d",
                         j, busy, done, depth, exp[6], exp[5], exp[4:0]);
                errs++;
            end
            op = ((j % 4) == 0) ? 2'd0 : 2'd1;
            if (j == 12) start = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_abort();
        logic [22:0] exp [4];
        exp[0] = {B_SPE | B_SPD, 1'b1, 1'b0, 2'b00, 3'd6, 5'd0};
        exp[1] = {B_SPO | B_MAE, 1'b1, 1'b0, 2'b00, 3'd6, 5'd1};
        exp[2] = {B_ROU | B_WE,  1'b1, 1'b1, 2'b00, 3'd6, 5'd1};
        exp[3] = {11'd0,         1'b0, 1'b0, 2'b00, 3'd0, 5'd1};
        do_reset();
        send(2'd2, 3'd1);
        tick(); tick();
        vecs++;
        if (strb() !== (B_PCO | B_WE)) begin
            $display("FAIL abort_write_pc: got %h required %h", strb(), B_PCO | B_WE);
            errs++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if (snap() !== 23'd0) begin
            $display("FAIL abort_state: got %h required %h", snap(), 23'd0);
            errs++;
        end
        tick();
        send(2'd0, 3'd6);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (snap() !== exp[i]) begin
                $display("FAIL post_abort_push step%0d: got %h required %h", i, snap(), exp[i]);
                errs++;
            end
            if (i < 3) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_abort();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
